// File: rtl/zap_wb_data_responder.sv
// Wishbone B3 classic-cycle data responder: word-addressed RAM behind a
// programmable wait-state FSM, with error termination outside the address window.
module zap_wb_data_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_adr,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic [31:0] o_xfer_count
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] WIN_BYTES = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state, state_nxt;
  logic [3:0]       wait_cnt, wait_cnt_nxt;
  logic             req, load_req, enter_resp;
  logic [31:0]      offset;
  logic             in_win;
  logic [IDX_W-1:0] lat_idx, resp_idx;
  logic             lat_we, lat_in_win, resp_we, resp_in_win;
  logic [3:0]       lat_sel;
  logic [31:0]      lat_dat;
  logic [31:0]      mem [DEPTH_WORDS];

  // Unsigned subtract makes addresses below the base wrap high and fail the window test.
  assign offset = i_wb_adr - BASE_ADDR;
  assign in_win = {1'b0, offset} < WIN_BYTES;
  assign req    = i_wb_cyc & i_wb_stb;

  // With zero wait states RESP is entered straight from IDLE, before the latches fill.
  assign resp_idx    = (state == S_IDLE) ? offset[IDX_W+1:2] : lat_idx;
  assign resp_we     = (state == S_IDLE) ? i_wb_we : lat_we;
  assign resp_in_win = (state == S_IDLE) ? in_win : lat_in_win;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    load_req     = 1'b0;
    enter_resp   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          load_req = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nxt  = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt    = S_WAIT;
            wait_cnt_nxt = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_nxt    = S_IDLE;
          wait_cnt_nxt = 4'd0;
        end else if (wait_cnt == 4'd0) begin
          state_nxt  = S_RESP;
          enter_resp = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lat_idx    <= '0;
      lat_we     <= 1'b0;
      lat_in_win <= 1'b0;
      lat_sel    <= 4'd0;
      lat_dat    <= 32'd0;
    end else if (load_req) begin
      lat_idx    <= offset[IDX_W+1:2];
      lat_we     <= i_wb_we;
      lat_in_win <= in_win;
      lat_sel    <= i_wb_sel;
      lat_dat    <= i_wb_dat;
    end
  end

  // Termination strobes are registered so they vanish the moment reset is asserted.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_wb_ack     <= 1'b0;
      o_wb_err     <= 1'b0;
      o_wb_dat     <= 32'd0;
      o_xfer_count <= 32'd0;
    end else begin
      o_wb_ack <= enter_resp & resp_in_win;
      o_wb_err <= enter_resp & ~resp_in_win;
      if (enter_resp && resp_in_win && !resp_we)
        o_wb_dat <= mem[resp_idx];
      if (state == S_RESP && lat_in_win)
        o_xfer_count <= o_xfer_count + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (state == S_RESP && lat_in_win && lat_we) begin
      for (int b = 0; b < 4; b++)
        if (lat_sel[b])
          mem[lat_idx][8*b +: 8] <= lat_dat[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_zap_wb_data_responder.sv
// Scoreboard bench for zap_wb_data_responder: three instances cover 1, 3 and 0 wait states.
module tb_zap_wb_data_responder;

  typedef struct {
    bit          is_err;
    bit          is_read;
    logic [31:0] dat;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        cyc   [3];
  logic        stb   [3];
  logic        we    [3];
  logic [31:0] adr   [3];
  logic [3:0]  sel   [3];
  logic [31:0] wdat  [3];
  logic [31:0] rdat  [3];
  logic        ack   [3];
  logic        err   [3];
  logic [31:0] count [3];

  exp_t        sb[$];
  logic [31:0] exp_count [3];
  logic [31:0] last_rd   [3];
  int          checks = 0;
  int          errors = 0;

  // Instance 0: WS=1 depth 64 base 0; 1: WS=3 depth 64 base 0; 2: WS=0 depth 16 base 0x100.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    zap_wb_data_responder #(
      .DEPTH_WORDS(g == 2 ? 16 : 64),
      .BASE_ADDR  (g == 2 ? 32'h0000_0100 : 32'h0000_0000),
      .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 3 : 0))
    ) u_dut (
      .i_clk       (clk),
      .i_reset_n   (reset_n),
      .i_wb_cyc    (cyc[g]),
      .i_wb_stb    (stb[g]),
      .i_wb_we     (we[g]),
      .i_wb_adr    (adr[g]),
      .i_wb_sel    (sel[g]),
      .i_wb_dat    (wdat[g]),
      .o_wb_dat    (rdat[g]),
      .o_wb_ack    (ack[g]),
      .o_wb_err    (err[g]),
      .o_xfer_count(count[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int ws_of(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  // One complete request: push the expectation, drive, wait (bounded) for termination, compare.
  task automatic do_xfer(input int d, input bit wr, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] wd, input bit oow, input logic [31:0] rd,
                         input string name);
    exp_t e;
    int   k;
    bit   got;
    e.is_err  = oow;
    e.is_read = !wr && !oow;
    e.dat     = oow ? last_rd[d] : rd;
    sb.push_back(e);
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = wr; adr[d] = a; sel[d] = s; wdat[d] = wd;
    k = 0; got = 1'b0;
    while (k < 40 && !got) begin
      @(posedge clk); #1;
      k++;
      got = ack[d] || err[d];
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL %s timeout: got no ack/err, required a response within 40 cycles", name);
      sb.delete();
      return;
    end
    e = sb.pop_front();
    checks++;
    if (k != 1 + ws_of(d)) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d cycles, required %0d", name, k, 1 + ws_of(d));
    end
    checks++;
    if ({ack[d], err[d]} !== (e.is_err ? 2'b01 : 2'b10)) begin
      errors++;
      $display("[TB] FAIL %s termination: got ack/err=%b%b, required %b", name, ack[d], err[d],
               e.is_err ? 2'b01 : 2'b10);
    end
    if (e.is_read || e.is_err) begin
      checks++;
      if (rdat[d] !== e.dat) begin
        errors++;
        $display("[TB] FAIL %s data: got %h, required %h", name, rdat[d], e.dat);
      end
    end
    if (e.is_read) last_rd[d] = e.dat;
    if (!e.is_err) exp_count[d] = exp_count[d] + 32'd1;
    @(posedge clk); #1;
    checks++;
    if (ack[d] || err[d]) begin
      errors++;
      $display("[TB] FAIL %s pulse: got ack/err=%b%b after one cycle, required 00", name, ack[d], err[d]);
    end
    checks++;
    if (count[d] !== exp_count[d]) begin
      errors++;
      $display("[TB] FAIL %s count: got %0d, required %0d", name, count[d], exp_count[d]);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      adr[d] = 32'd0; sel[d] = 4'd0; wdat[d] = 32'd0;
      exp_count[d] = 32'd0; last_rd[d] = 32'd0;
    end
    #3;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({ack[d], err[d]} !== 2'b00 || rdat[d] !== 32'd0 || count[d] !== 32'd0) begin
        errors++;
        $display("[TB] FAIL reset_state[%0d]: got ack=%b err=%b dat=%h count=%h, required all zero",
                 d, ack[d], err[d], rdat[d], count[d]);
      end
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_write_read;
    do_xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, "wr_write");
    do_xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, "wr_read");
    checks++;
    if (count[0] !== 32'd2) begin
      errors++;
      $display("[TB] FAIL wr_total_count: got %0d, required 2", count[0]);
    end
  endtask

  task automatic test_byte_lanes;
    do_xfer(0, 1'b1, 32'h14, 4'hF, 32'h11223344, 1'b0, 32'h0, "bl_init");
    do_xfer(0, 1'b1, 32'h14, 4'b0101, 32'hAABBCCDD, 1'b0, 32'h0, "bl_partial");
    do_xfer(0, 1'b0, 32'h14, 4'hF, 32'h0, 1'b0, 32'h11BB33DD, "bl_read");
    do_xfer(0, 1'b1, 32'h14, 4'h0, 32'h0, 1'b0, 32'h0, "bl_sel0");
    do_xfer(0, 1'b0, 32'h14, 4'hF, 32'h0, 1'b0, 32'h11BB33DD, "bl_read_after_sel0");
  endtask

  task automatic test_out_of_window;
    do_xfer(0, 1'b0, 32'h100, 4'hF, 32'h0, 1'b1, 32'h0, "oow_above");
    do_xfer(0, 1'b1, 32'hFC, 4'hF, 32'h0F0F0F0F, 1'b0, 32'h0, "oow_last_write");
    do_xfer(0, 1'b0, 32'hFC, 4'hF, 32'h0, 1'b0, 32'h0F0F0F0F, "oow_last_read");
    do_xfer(2, 1'b0, 32'hFC, 4'hF, 32'h0, 1'b1, 32'h0, "oow_below_base");
    do_xfer(2, 1'b1, 32'h140, 4'hF, 32'h12345678, 1'b1, 32'h0, "oow_write_above");
    do_xfer(2, 1'b1, 32'h13C, 4'hF, 32'h600DCAFE, 1'b0, 32'h0, "oow_top_write");
    do_xfer(2, 1'b0, 32'h13C, 4'hF, 32'h0, 1'b0, 32'h600DCAFE, "oow_top_read");
  endtask

  task automatic test_abort;
    bit seen;
    do_xfer(1, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0, "ab_init");
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h20; sel[1] = 4'hF; wdat[1] = 32'h12345678;
    @(posedge clk);
    @(posedge clk); #1;
    stb[1] = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ack[1] || err[1]) seen = 1'b1;
    end
    cyc[1] = 1'b0;
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL abort_no_response: got a termination, required none");
    end
    checks++;
    if (count[1] !== exp_count[1]) begin
      errors++;
      $display("[TB] FAIL abort_count: got %0d, required %0d", count[1], exp_count[1]);
    end
    do_xfer(1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 32'hCAFEF00D, "ab_readback");
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   k;
    bit   got;
    for (int i = 0; i < 4; i++)
      do_xfer(2, 1'b1, 32'h100 + 32'(4 * i), 4'hF, 32'hA000_0000 + 32'(i), 1'b0, 32'h0, "b2b_fill");
    for (int i = 0; i < 4; i++) begin
      e.is_err = 1'b0; e.is_read = 1'b1; e.dat = 32'hA000_0000 + 32'(i);
      sb.push_back(e);
    end
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; sel[2] = 4'hF; adr[2] = 32'h100;
    for (int i = 0; i < 4; i++) begin
      k = 0; got = 1'b0;
      while (k < 10 && !got) begin
        @(posedge clk); #1;
        k++;
        got = ack[2];
      end
      e = sb.pop_front();
      checks++;
      if (!got || k != ((i == 0) ? 1 : 2)) begin
        errors++;
        $display("[TB] FAIL b2b_spacing[%0d]: got ack after %0d cycles (seen=%b), required %0d",
                 i, k, got, (i == 0) ? 1 : 2);
      end
      checks++;
      if (rdat[2] !== e.dat) begin
        errors++;
        $display("[TB] FAIL b2b_data[%0d]: got %h, required %h", i, rdat[2], e.dat);
      end
      last_rd[2] = e.dat;
      exp_count[2] = exp_count[2] + 32'd1;
      if (i < 3) adr[2] = 32'h100 + 32'(4 * (i + 1));
      else begin
        cyc[2] = 1'b0; stb[2] = 1'b0;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (count[2] !== exp_count[2]) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d, required %0d", count[2], exp_count[2]);
    end
  endtask

  task automatic test_async_reset;
    bit seen;
    do_xfer(1, 1'b1, 32'h24, 4'hF, 32'h0BADF00D, 1'b0, 32'h0, "ar_init");
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h24; sel[1] = 4'hF; wdat[1] = 32'h55555555;
    @(posedge clk);
    @(posedge clk); #2;
    reset_n = 1'b0;
    cyc[1] = 1'b0; stb[1] = 1'b0;
    #1;
    checks++;
    if (ack[1] !== 1'b0 || err[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ar_strobes: got ack=%b err=%b, required 0 0", ack[1], err[1]);
    end
    checks++;
    if (count[1] !== 32'd0 || count[0] !== 32'd0) begin
      errors++;
      $display("[TB] FAIL ar_count: got %0d/%0d, required 0/0", count[1], count[0]);
    end
    checks++;
    if (rdat[0] !== 32'd0) begin
      errors++;
      $display("[TB] FAIL ar_dat: got %h, required 0", rdat[0]);
    end
    for (int d = 0; d < 3; d++) begin
      exp_count[d] = 32'd0;
      last_rd[d]   = 32'd0;
    end
    #1;
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack[1] || err[1]) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL ar_quiet: got a termination after reset, required none");
    end
    do_xfer(1, 1'b0, 32'h24, 4'hF, 32'h0, 1'b0, 32'h0BADF00D, "ar_readback");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_out_of_window();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
